// File: rtl/mram_sp_be_init.sv
// Single-port RAM with per-byte write enables, a registered read port that holds
// its value, and a hardware sweep that zeroes every entry after reset or on request.
module mram_sp_be_init #(
    parameter int P_DW       = 6,
    parameter int AW         = 6,
    parameter bit CLR_ON_RST = 1'b1,
    localparam int DW        = 1 << P_DW
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CLR,
    output logic            BUSY,
    input  logic [AW-1:0]   ADDR,
    input  logic            RE,
    output logic [DW-1:0]   DOUT,
    input  logic [DW/8-1:0] WE,
    input  logic [DW-1:0]   DIN
);

    localparam int DEPTH = 1 << AW;
    localparam int NB    = DW / 8;
    localparam logic [AW-1:0] CNT_LAST = '1;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            start_clr;
    logic [DW-1:0]   mem [DEPTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_clr = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (CLR) begin
                    state_d   = S_CLEAR;
                    cnt_d     = '0;
                    start_clr = 1'b1;
                end
            end
            S_CLEAR: begin
                // Counter parks on the last entry so entry 0 is never re-cleared.
                if (cnt_q == CNT_LAST) state_d = S_IDLE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= CLR_ON_RST ? S_CLEAR : S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign BUSY = (state_q == S_CLEAR);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state_q == S_CLEAR) begin
                mem[cnt_q] <= '0;
            end else begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (WE[i]) mem[ADDR][8*i +: 8] <= DIN[8*i +: 8];
                end
            end
        end
    end

    // Read-first: DOUT samples the array before a same-cycle write lands;
    // a sweep start forces zero even if a read was accepted on that edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT <= '0;
        end else if (state_q == S_IDLE) begin
            if (start_clr)  DOUT <= '0;
            else if (RE)    DOUT <= mem[ADDR];
        end
    end

endmodule

// File: tb/tb_mram_sp_be_init.sv
// Randomized and directed checks of mram_sp_be_init against an array-level model.
module tb_mram_sp_be_init;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST, CLR, RE, BUSY;
    logic [3:0]  ADDR;
    logic [7:0]  WE;
    logic [63:0] DIN, DOUT;

    logic        b_rst, b_clr, b_re, b_busy;
    logic [3:0]  b_addr;
    logic [7:0]  b_we;
    logic [63:0] b_din, b_dout;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_mem [DEPTH];
    logic [63:0] m_dout;
    int          m_busy;

    always #5 CLK = ~CLK;

    mram_sp_be_init #(.P_DW(6), .AW(4), .CLR_ON_RST(1'b1)) dut_a (
        .CLK(CLK), .RST(RST), .CLR(CLR), .BUSY(BUSY), .ADDR(ADDR),
        .RE(RE), .DOUT(DOUT), .WE(WE), .DIN(DIN)
    );

    mram_sp_be_init #(.P_DW(6), .AW(4), .CLR_ON_RST(1'b0)) dut_b (
        .CLK(CLK), .RST(b_rst), .CLR(b_clr), .BUSY(b_busy), .ADDR(b_addr),
        .RE(b_re), .DOUT(b_dout), .WE(b_we), .DIN(b_din)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of dut_a: apply inputs, advance the model, compare after the edge.
    task automatic step(input logic rst, input logic clr, input logic re,
                        input logic [7:0] we, input logic [3:0] addr, input logic [63:0] din);
        logic [63:0] rd;
        RST = rst; CLR = clr; RE = re; WE = we; ADDR = addr; DIN = din;
        @(posedge CLK);
        if (rst) begin
            m_dout = '0;
            m_busy = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else begin
            rd = m_mem[addr];
            for (int b = 0; b < 8; b++)
                if (we[b]) m_mem[addr][8*b +: 8] = din[8*b +: 8];
            if (clr) begin
                m_dout = '0;
                m_busy = DEPTH;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end else if (re) begin
                m_dout = rd;
            end
        end
        #1;
        check("busy", {63'd0, BUSY}, {63'd0, m_busy > 0});
        check("dout", DOUT, m_dout);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 64'd0);
    endtask

    task automatic count_sweep(input string tag);
        int n = 0;
        while (BUSY && n < 40) begin
            idle();
            n++;
        end
        check(tag, 64'(n), 64'd16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        b_rst = 1'b1; b_clr = 1'b0; b_re = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
        m_busy = 0; m_dout = '0;

        // Reset sweep and empty readback
        step(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 64'd0);
        check("rst_busy", {63'd0, BUSY}, 64'd1);
        check("rst_dout", DOUT, 64'd0);
        count_sweep("rst_sweep_len");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 8'h00, 4'(i), 64'd0);

        // Byte-lane writes
        step(1'b0, 1'b0, 1'b0, 8'hFF, 4'd3, 64'h1122334455667788);
        step(1'b0, 1'b0, 1'b0, 8'h0F, 4'd3, 64'hAAAAAAAAAAAAAAAA);
        step(1'b0, 1'b0, 1'b1, 8'h00, 4'd3, 64'd0);
        check("byte_merge", DOUT, 64'h11223344AAAAAAAA);

        // Read-first collision and hold
        step(1'b0, 1'b0, 1'b0, 8'hFF, 4'd5, 64'h5);
        step(1'b0, 1'b0, 1'b1, 8'hFF, 4'd5, 64'h9);
        check("read_first", DOUT, 64'h5);
        for (int i = 0; i < 3; i++) idle();
        check("hold", DOUT, 64'h5);
        step(1'b0, 1'b0, 1'b1, 8'h00, 4'd5, 64'd0);
        check("after_write", DOUT, 64'h9);

        // CLR in idle after filling, with a same-cycle read
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b0, 1'b0, 8'hFF, 4'(i), {$urandom, $urandom} | 64'h1);
        step(1'b0, 1'b1, 1'b1, 8'h00, 4'd7, 64'd0);
        check("clr_dout0", DOUT, 64'd0);
        count_sweep("clr_sweep_len");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 8'h00, 4'(i), 64'd0);

        // Dropped write while busy, then RST at sweep cycle 7
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b0, 1'b0, 8'hFF, 4'(i), 64'h1234 + 64'(i));
        step(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 64'd0);
        step(1'b0, 1'b0, 1'b0, 8'hFF, 4'd2, 64'hFF);
        step(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 64'd0);
        for (int i = 0; i < 4; i++) idle();
        step(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 64'd0);
        count_sweep("restart_sweep_len");
        step(1'b0, 1'b0, 1'b1, 8'h00, 4'd2, 64'd0);
        check("dropped_write", DOUT, 64'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
                 1'($urandom), $urandom_range(0, 1) ? 8'($urandom) : 8'h00,
                 4'($urandom), {$urandom, $urandom});
        end

        // Second instance: no sweep on reset
        @(negedge CLK);
        b_rst = 1'b1;
        @(posedge CLK); #1;
        b_rst = 1'b0;
        check("b_rst_busy", {63'd0, b_busy}, 64'd0);
        check("b_rst_dout", b_dout, 64'd0);
        b_we = 8'hFF; b_addr = 4'd1; b_din = 64'hCAFEF00D12345678;
        @(posedge CLK); #1;
        check("b_busy_idle", {63'd0, b_busy}, 64'd0);
        check("b_no_read", b_dout, 64'd0);
        b_we = 8'h00; b_re = 1'b1;
        @(posedge CLK); #1;
        b_re = 1'b0;
        check("b_read", b_dout, 64'hCAFEF00D12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mram_sp_be_init.md
# mram_sp_be_init

Parametrised single-port synchronous RAM with per-byte write enables, a registered and held read port, and a built-in hardware-clear sequencer. After reset, or on request, the block zeroes every entry before it accepts any access, so cache tag and valid arrays never have to be scrubbed by software. It is the next-generation storage primitive beneath the L1 cache tag, data and valid arrays and the TLB arrays. Read/write collision and read-hold behaviour are fully specified, not left undefined.

## Interface
- P_DW, 6: log2 of the data width in bits. Must be ≥3; data width is DW = 1<<P_DW.
- AW, 6: address width. Depth is 1<<AW entries.
- CLR_ON_RST, 1: 1 = run a clear sweep after reset; 0 = come out of reset idle, with contents undefined.
- CLK  in  1  clock, posedge.
- RST  in  1  synchronous active-high reset.
- CLR  in  1  clear request, sampled only in IDLE.
- BUSY  out  1  clear sweep in progress; RE, WE and CLR are ignored while high.
- ADDR  in  AW  access address.
- RE  in  1  read enable.
- DOUT  out  DW  registered read data.
- WE  in  DW/8  byte write enables, bit i covering DIN[8i+7:8i].
- DIN  in  DW  write data.

## Operation
- FSM states:
  - IDLE: normal accesses.
  - CLEAR: a sweep counter cnt (AW bits) writes all-zero to entry cnt each cycle, then cnt increments.
- Transitions:
  - RST → CLEAR with cnt=0 if CLR_ON_RST=1, otherwise → IDLE.
  - IDLE with CLR=1 → CLEAR, cnt=0.
  - CLEAR with cnt = (1<<AW)-1 → IDLE after that entry is written.
  - CLR during CLEAR is ignored; it does not restart the sweep.
- BUSY=1 exactly while in CLEAR, and is a registered function of state.
- Read path:
  - An accepted read (RE=1 in IDLE) loads DOUT with mem[ADDR] at the next edge.
  - DOUT holds its value until the next accepted read, regardless of intervening writes, including writes to the same address.
- Write path:
  - Each byte i with WE[i]=1 in IDLE updates mem[ADDR] byte i at the edge.
  - Bytes with WE[i]=0 are untouched. WE=0 means no write.
- Read and write in the same cycle (same ADDR by construction): read-first. DOUT returns the pre-write contents for all bytes, and the write still commits.
- Starting a CLEAR, whether from CLR or from RST, sets DOUT to 0 on that edge. DOUT stays 0 until the first accepted read after BUSY falls.
- Accesses presented while BUSY=1 are dropped: no memory change, no DOUT update. Callers must stall on BUSY.
- CLR and RE/WE asserted in the same IDLE cycle: the access is performed and the sweep starts on the same edge. The sweep then overwrites that entry with zero.

## Timing
- Reset values:
  - DOUT=0.
  - BUSY=1 if CLR_ON_RST else 0, valid in the first cycle after RST deasserts.
  - cnt=0.
  - Memory contents are not reset by RST itself.
- Clear duration:
  - Exactly 1<<AW cycles with BUSY=1.
  - If CLR is sampled at edge t, BUSY is high for cycles t+1 … t+(1<<AW).
  - The first access is accepted at cycle t+(1<<AW)+1.
- Read latency is 1 cycle: ADDR/RE at cycle t, data on DOUT after edge t+1, held indefinitely.
- Write latency: visible to a read issued in the following cycle (write at t, RE at t+1 → new data on DOUT at t+2).
- RST mid-sweep: the sweep restarts from cnt=0 (CLR_ON_RST=1) or aborts to IDLE with partial contents (CLR_ON_RST=0).
- cnt wrap: the counter stops at (1<<AW)-1; it must not wrap and re-clear entry 0.
- No combinational path from any input to DOUT or BUSY.

## Test plan
- Reset sweep (P_DW=6, AW=4, CLR_ON_RST=1): pulse RST for 1 cycle → BUSY high for exactly 16 cycles. Then read all 16 addresses → DOUT=64'h0 each time, 1 cycle after RE.
- Byte writes: write 64'h1122334455667788 with WE=8'hFF to addr 3, then 64'hAAAAAAAAAAAAAAAA with WE=8'h0F to addr 3, then read addr 3 → DOUT=64'h11223344AAAAAAAA.
- Read-first and hold: addr 5 holds 64'h5. Issue RE=1 with WE=8'hFF and DIN=64'h9 → DOUT=64'h5. Hold RE=0 for 3 cycles → DOUT stays 64'h5. Read again → 64'h9.
- CLR in IDLE: fill addr 0..15 with nonzero data, pulse CLR → BUSY for 16 cycles and DOUT=0 during the sweep. Afterwards, reads of all addresses return 0.
- Drop while busy, and RST mid-sweep:
  - With BUSY=1, issue a write of 64'hFF to addr 2 → after the sweep, addr 2 reads 0.
  - Assert RST at sweep cycle 7 → BUSY stays high for a further 16 cycles from the restart.
- CLR_ON_RST=0: RST → BUSY=0 on the first cycle and DOUT=0. A write then a read of addr 1 works immediately, with 1-cycle read latency.
